ew_vehicle_detector: RTL and testbench
======================================

Name: ew_vehicle_detector

Overview:
- Conditions the raw east-west inductive-loop sensor into the clean vehicle-present request consumed by the traffic-light FSM's east-west vehicle-detect input.
- Synchronises the asynchronous sensor and rejects glitches with a qualify counter.
- Bridges short dropouts with a hold counter.
- Counts qualified vehicle arrivals for monitoring.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high samples required to declare presence (legal >= 2).
- HOLD_CYCLES, 8: consecutive synchronised-low samples required to declare absence (legal >= 2).
- CNT_W, 8: width of the saturating arrival counter.

Ports:
- i_clk  in  1  system clock, all flops rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_loop_raw  in  1  raw loop sensor, asynchronous to i_clk, 1 = metal detected.
- i_cnt_clr  in  1  synchronous clear of o_veh_count.
- o_ew_vd  out  1  qualified vehicle present, registered; drives the FSM east-west vehicle-detect input.
- o_veh_arrive  out  1  one-cycle pulse on each new qualified arrival.
- o_veh_count  out  CNT_W  saturating count of qualified arrivals.
- o_state  out  2  FSM state for debug: IDLE=0, QUALIFY=1, PRESENT=2, HOLD=3.

Behaviour:
- Reset (i_rst_n=0, asynchronous, no clock edge needed):
  - sync flops, deb_cnt, hold_cnt, o_ew_vd, o_veh_arrive and o_veh_count all clear to 0.
  - state = IDLE.
- Synchroniser: two-flop chain, sync1 <= i_loop_raw, s <= sync1. The FSM samples only s.
- Counter widths: deb_cnt is $clog2(DEBOUNCE_CYCLES) bits; hold_cnt is $clog2(HOLD_CYCLES) bits.
- IDLE (o_ew_vd=0):
  - s=1 -> QUALIFY, deb_cnt <= 1.
  - else stay.
- QUALIFY (o_ew_vd=0):
  - s=0 -> IDLE, deb_cnt <= 0.
  - s=1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESENT; o_ew_vd <= 1, o_veh_arrive <= 1, arrival increment.
  - else deb_cnt++.
- PRESENT (o_ew_vd=1):
  - s=0 -> HOLD, hold_cnt <= 1.
  - else stay.
- HOLD (o_ew_vd=1):
  - s=1 -> PRESENT, hold_cnt <= 0. Same vehicle: no arrival pulse, no count.
  - s=0 and hold_cnt == HOLD_CYCLES-1 -> IDLE, o_ew_vd <= 0.
  - else hold_cnt++.
- Latency: let edge k be the first i_clk edge at which sync1 captures the new raw level.
  - o_ew_vd rises after edge k+DEBOUNCE_CYCLES+1 (default k+5).
  - o_ew_vd falls after edge k+HOLD_CYCLES+1 (default k+9).
- o_veh_arrive: high for exactly the one cycle in which o_ew_vd first goes 1. Low in all other cycles.
- Counter:
  - increments by 1 on each arrival.
  - saturates at 2^CNT_W-1 (no wrap).
  - i_cnt_clr=1 -> 0 next edge.
  - i_cnt_clr and an arrival on the same edge -> count = 1.
- Glitch rejection: a high pulse shorter than DEBOUNCE_CYCLES samples never asserts o_ew_vd. A low gap shorter than HOLD_CYCLES samples never deasserts it.
- Reset mid-operation (any state): all outputs drop to 0 immediately. After release, detection restarts from IDLE; a still-present vehicle is re-qualified and counted again.
- Unused encodings: none (2-bit state fully used). A defensive default branch returns to IDLE.

Test Plan:
1. Hold i_rst_n=0 with i_loop_raw=1 -> all outputs 0, o_state=0. Release reset -> o_ew_vd=1 after the 6th edge after release; o_veh_count=1; o_veh_arrive high exactly 1 cycle.
2. Clock-aligned raw high for 3 cycles, then low -> o_ew_vd stays 0, o_veh_count unchanged, o_state returns to 0.
3. Raw high for 20 cycles, then low -> o_ew_vd rises 5 edges after capture and falls 9 edges after the low level is captured; count increments 0->1.
4. During presence, raw low for 5 cycles then high again -> o_ew_vd remains 1 throughout (state HOLD->PRESENT); no pulse; count unchanged.
5. CNT_W=8, 260 clean arrivals -> o_veh_count=255 and holds.
   - Assert i_cnt_clr -> 0 on the next edge.
   - i_cnt_clr coincident with an arrival -> 1.
6. Assert i_rst_n=0 asynchronously mid-PRESENT, between clock edges -> o_ew_vd, o_veh_count and o_state go to 0 without a clock edge; after release with raw=1, re-qualification takes 6 edges.

Source files
------------

// File: rtl/ew_vehicle_detector.sv
// East-west inductive-loop conditioner: synchronises the raw loop sensor, debounces
// arrivals, bridges short dropouts and counts qualified vehicle arrivals.
module ew_vehicle_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8,
   parameter int CNT_W           = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_loop_raw,
   input  logic             i_cnt_clr,
   output logic             o_ew_vd,
   output logic             o_veh_arrive,
   output logic [CNT_W-1:0] o_veh_count,
   output logic [1:0]       o_state
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      PRESENT = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic              sync1_r, sync2_r;
   logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_nxt_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
   logic              ew_vd_r, ew_vd_nxt_s;
   logic              arrive_r, arrive_nxt_s;
   logic [CNT_W-1:0]  count_r, count_nxt_s;

   // Two-flop synchroniser for the asynchronous loop input
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= i_loop_raw;
         sync2_r <= sync1_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= IDLE;
         deb_cnt_r  <= '0;
         hold_cnt_r <= '0;
         ew_vd_r    <= 1'b0;
         arrive_r   <= 1'b0;
         count_r    <= '0;
      end else begin
         state_r    <= state_nxt_s;
         deb_cnt_r  <= deb_cnt_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         ew_vd_r    <= ew_vd_nxt_s;
         arrive_r   <= arrive_nxt_s;
         count_r    <= count_nxt_s;
      end
   end

   // Next-state decode, debounce/hold counting and arrival detection
   always_comb begin
      state_nxt_s    = state_r;
      deb_cnt_nxt_s  = deb_cnt_r;
      hold_cnt_nxt_s = hold_cnt_r;
      ew_vd_nxt_s    = ew_vd_r;
      arrive_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            ew_vd_nxt_s = 1'b0;
            if (sync2_r) begin
               state_nxt_s   = QUALIFY;
               deb_cnt_nxt_s = DEB_W'(1);
            end else begin
               state_nxt_s   = IDLE;
            end
         end
         QUALIFY: begin
            if (!sync2_r) begin
               state_nxt_s   = IDLE;
               deb_cnt_nxt_s = '0;
               ew_vd_nxt_s   = 1'b0;
            end else if (deb_cnt_r == DEB_LAST) begin
               state_nxt_s   = PRESENT;
               deb_cnt_nxt_s = '0;
               ew_vd_nxt_s   = 1'b1;
               arrive_nxt_s  = 1'b1;
            end else begin
               deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
               ew_vd_nxt_s   = 1'b0;
            end
         end
         PRESENT: begin
            ew_vd_nxt_s = 1'b1;
            if (!sync2_r) begin
               state_nxt_s    = HOLD;
               hold_cnt_nxt_s = HOLD_W'(1);
            end else begin
               state_nxt_s    = PRESENT;
            end
         end
         HOLD: begin
            // A returning signal is the same vehicle, so no new arrival is flagged
            if (sync2_r) begin
               state_nxt_s    = PRESENT;
               hold_cnt_nxt_s = '0;
               ew_vd_nxt_s    = 1'b1;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_nxt_s    = IDLE;
               hold_cnt_nxt_s = '0;
               ew_vd_nxt_s    = 1'b0;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
               ew_vd_nxt_s    = 1'b1;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            deb_cnt_nxt_s  = '0;
            hold_cnt_nxt_s = '0;
            ew_vd_nxt_s    = 1'b0;
         end
      endcase
   end

   // Saturating arrival counter; a clear coinciding with an arrival lands on one
   always_comb begin
      count_nxt_s = count_r;
      if (i_cnt_clr) begin
         count_nxt_s = arrive_nxt_s ? CNT_W'(1) : '0;
      end else if (arrive_nxt_s && (count_r != CNT_MAX)) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   assign o_ew_vd      = ew_vd_r;
   assign o_veh_arrive = arrive_r;
   assign o_veh_count  = count_r;
   assign o_state      = state_r;

endmodule

// File: tb/tb_ew_vehicle_detector.sv
// Scoreboard bench for ew_vehicle_detector: each scenario pushes the expected
// outputs for every edge and pops/compares them once the edge has happened.
module tb_ew_vehicle_detector;

   typedef struct packed {
      logic       vd;
      logic       arr;
      logic [7:0] cnt;
      logic [1:0] st;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       loop_raw = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       ew_vd;
   logic       veh_arrive;
   logic [7:0] veh_count;
   logic [1:0] state;

   obs_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   exp_cnt = 0;

   ew_vehicle_detector #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_loop_raw  (loop_raw),
      .i_cnt_clr   (cnt_clr),
      .o_ew_vd     (ew_vd),
      .o_veh_arrive(veh_arrive),
      .o_veh_count (veh_count),
      .o_state     (state)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input logic vd, input logic arr, input int cnt, input int st);
      obs_t e;
      e.vd  = vd;
      e.arr = arr;
      e.cnt = 8'(cnt);
      e.st  = 2'(st);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected state after edge j when raw has been high since edge 1
   function automatic int qual_state(input int j);
      if (j <= 2) return 0;
      else if (j <= 5) return 1;
      else return 2;
   endfunction

   task automatic test_reset();
      obs_t e, a;
      rst_n = 1'b0; loop_raw = 1'b1; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a = {ew_vd, veh_arrive, veh_count, state};
      checks++;
      if (a !== 12'd0) $display("FAIL reset_hold: got %h want 000", a);
      else passed++;
      rst_n = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         push_exp(j >= 6, j == 6, (j >= 6) ? 1 : 0, qual_state(j));
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL reset_release edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      exp_cnt = 1;
   endtask

   task automatic test_release_clear();
      obs_t e, a;
      loop_raw = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         push_exp(j <= 9, 1'b0, exp_cnt, (j <= 2) ? 2 : (j <= 9) ? 3 : 0);
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL release edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      cnt_clr = 1'b1;
      exp_cnt = 0;
      push_exp(1'b0, 1'b0, exp_cnt, 0);
      tick();
      cnt_clr = 1'b0;
      e = exp_q.pop_front();
      a = {ew_vd, veh_arrive, veh_count, state};
      checks++;
      if (a !== e) $display("FAIL count_clear: got cnt=%0d want cnt=%0d (full %h vs %h)", a.cnt, e.cnt, a, e);
      else passed++;
   endtask

   task automatic test_glitch();
      obs_t e, a;
      for (int j = 1; j <= 8; j++) begin
         loop_raw = (j <= 3);
         push_exp(1'b0, 1'b0, exp_cnt, (j >= 3 && j <= 5) ? 1 : 0);
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL glitch edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      loop_raw = 1'b0;
   endtask

   task automatic test_presence();
      obs_t e, a;
      int st;
      for (int j = 1; j <= 32; j++) begin
         loop_raw = (j <= 20);
         if (j <= 22) st = qual_state(j);
         else if (j <= 29) st = 3;
         else st = 0;
         push_exp(j >= 6 && j <= 29, j == 6, exp_cnt + ((j >= 6) ? 1 : 0), st);
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL presence edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      exp_cnt++;
      loop_raw = 1'b0;
   endtask

   task automatic test_dropout();
      obs_t e, a;
      int st;
      for (int j = 1; j <= 42; j++) begin
         loop_raw = (j <= 12) || (j >= 18 && j <= 30);
         if (j <= 14) st = qual_state(j);
         else if (j <= 19) st = 3;
         else if (j <= 32) st = 2;
         else if (j <= 39) st = 3;
         else st = 0;
         push_exp(j >= 6 && j <= 39, j == 6, exp_cnt + ((j >= 6) ? 1 : 0), st);
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL dropout edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      exp_cnt++;
      loop_raw = 1'b0;
   endtask

   // One clean 14-edge arrival; optionally clears the counter on the arrival edge
   task automatic arrival(input logic clr_on_arrival, input string tag);
      obs_t e, a;
      for (int j = 1; j <= 14; j++) begin
         loop_raw = (j <= 4);
         cnt_clr  = clr_on_arrival && (j == 6);
         if (j == 6) begin
            if (clr_on_arrival) exp_cnt = 1;
            else if (exp_cnt < 255) exp_cnt++;
            else exp_cnt = 255;
            push_exp(1'b1, 1'b1, exp_cnt, 2);
         end else if (j == 14) begin
            push_exp(1'b0, 1'b0, exp_cnt, 0);
         end
         tick();
         cnt_clr = 1'b0;
         if (j == 6 || j == 14) begin
            e = exp_q.pop_front();
            a = {ew_vd, veh_arrive, veh_count, state};
            checks++;
            if (a !== e) $display("FAIL %s edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                                  tag, j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
            else passed++;
         end
      end
   endtask

   task automatic test_saturate();
      obs_t e, a;
      for (int n = 0; n < 260; n++) arrival(1'b0, "saturate");
      for (int j = 1; j <= 3; j++) begin
         push_exp(1'b0, 1'b0, 255, 0);
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL sat_hold edge %0d: got cnt=%0d want cnt=%0d", j, a.cnt, e.cnt);
         else passed++;
      end
      cnt_clr = 1'b1;
      exp_cnt = 0;
      push_exp(1'b0, 1'b0, 0, 0);
      tick();
      cnt_clr = 1'b0;
      e = exp_q.pop_front();
      a = {ew_vd, veh_arrive, veh_count, state};
      checks++;
      if (a !== e) $display("FAIL sat_clear: got cnt=%0d want cnt=%0d", a.cnt, e.cnt);
      else passed++;
      arrival(1'b0, "post_clear");
      arrival(1'b0, "post_clear");
      arrival(1'b1, "clr_with_arrival");
   endtask

   task automatic test_async_reset();
      obs_t e, a;
      loop_raw = 1'b1;
      repeat (8) tick();
      a = {ew_vd, veh_arrive, veh_count, state};
      checks++;
      if (a.vd !== 1'b1 || a.st !== 2'd2) $display("FAIL pre_reset_present: got vd=%b st=%0d want vd=1 st=2", a.vd, a.st);
      else passed++;
      #3;
      rst_n = 1'b0;
      #1;
      a = {ew_vd, veh_arrive, veh_count, state};
      checks++;
      if (a !== 12'd0) $display("FAIL async_reset: got %h want 000", a);
      else passed++;
      #2;
      rst_n = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         push_exp(j >= 6, j == 6, (j >= 6) ? 1 : 0, qual_state(j));
         tick();
         e = exp_q.pop_front();
         a = {ew_vd, veh_arrive, veh_count, state};
         checks++;
         if (a !== e) $display("FAIL requalify edge %0d: got vd=%b arr=%b cnt=%0d st=%0d want vd=%b arr=%b cnt=%0d st=%0d",
                               j, a.vd, a.arr, a.cnt, a.st, e.vd, e.arr, e.cnt, e.st);
         else passed++;
      end
      loop_raw = 1'b0;
   endtask

   initial begin
      test_reset();
      test_release_clear();
      test_glitch();
      test_presence();
      test_dropout();
      test_saturate();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
